if_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage. Replaces the fixed free-running PC+4 fetcher.
- Owns the PC and drives a synchronous-read instruction ROM (1-cycle read latency).
- Presents fetched instructions to decode through a valid/ready handshake.
- Accepts branch/jump redirects from downstream stages.

---
 rtl/if_fetch_unit.sv | 88 ++++++++
 tb/tb_if_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: parametrised instruction-fetch stage.
// Owns the PC, drives a synchronous-read instruction ROM (1-cycle latency) and
// hands fetched words to decode over a valid/ready handshake. Downstream
// redirects discard the in-flight fetch and restart from redirect_pc.
// Optional feature macro: IF_MISALIGN_CHK_EN. When it is defined, a misaligned
// redirect raises a sticky fetch_err and halts fetch until reset.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                ROM_AW   = 6,
  parameter logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000,
  parameter int                INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fetch_err
);

  logic [ADDR_W-1:0] pc;        // next address to issue
  logic [ADDR_W-1:0] f2_pc;     // PC of the word the ROM is returning
  logic              f2_valid;  // ROM output holds a live instruction
  logic [ADDR_W-1:0] redir_tgt; // PC loaded on a redirect
  logic              halt;      // fetch frozen after a bad redirect
  logic              advance;
  logic              issue;

`ifdef IF_MISALIGN_CHK_EN
  logic err_q;

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      err_q <= 1'b1;
  end

  assign halt      = err_q;
  assign fetch_err = err_q;
  assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
`else
  assign halt      = 1'b0;
  assign fetch_err = 1'b0;
  assign redir_tgt = redirect_pc;
`endif

  // Output slot is free when empty or being drained this cycle.
  assign advance  = !f2_valid || out_ready;
  // A redirect cancels any same-cycle issue; reset suppresses the ROM read.
  assign issue    = advance && !redirect && !rst && !halt;

  assign rom_en   = issue;
  assign rom_addr = pc[ROM_AW+1:2];

  // The ROM output register holds while rom_en is low, so out_inst is stable
  // during a stall without a local copy.
  assign out_valid = f2_valid;
  assign out_inst  = rom_data;
  assign out_pc    = f2_pc;

  // PC / fetch-stage state: reset > redirect > issue > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= PC_RESET;
      f2_valid <= 1'b0;
      f2_pc    <= '0;
    end else if (redirect) begin
      pc       <= redir_tgt;
      f2_valid <= 1'b0;
    end else if (issue) begin
      pc       <= pc + ADDR_W'(4);
      f2_valid <= 1'b1;
      f2_pc    <= pc;
    end else if (advance) begin
      // Only reachable while halted: the slot drains and stays empty.
      f2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed + randomized bench for if_fetch_unit with a
// scoreboard. The stimulus side pushes the expected instruction stream
// (pc, inst) whenever fetch (re)starts; a negedge monitor pops and compares
// on every handshake transfer.
module tb_if_fetch_unit;
  localparam int ADDR_W = 32;
  localparam int ROM_AW = 6;
  localparam int INST_W = 32;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [INST_W-1:0] rom_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              fetch_err;

  int total = 0;
  int bad   = 0;
  int ntx   = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [INST_W-1:0] rom [64];

  if_fetch_unit #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW), .PC_RESET(PC_RST), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM; output register holds when not enabled.
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after (re)starting at 'start', transfers carry start, start+4, ...
  // and the instruction is ROM word ((pc / 4) mod 64), which holds that index.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_pc_q.delete();
    exp_inst_q.delete();
    p = start;
    for (int i = 0; i < 200; i++) begin
      exp_pc_q.push_back(p);
      exp_inst_q.push_back((p >> 2) % 64);
      p = p + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect = 1'b1;
    redirect_pc = tgt;
    step();
    redirect = 1'b0;
    push_stream(tgt);
  endtask

  // Monitor: every transfer must match the head of the expected stream.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      ntx++;
      total++;
      if (exp_pc_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: unexpected transfer pc=%h at %0t", out_pc, $time);
      end else begin
        logic [31:0] ep, ei;
        ep = exp_pc_q.pop_front();
        ei = exp_inst_q.pop_front();
        if (out_pc !== ep || out_inst !== ei) begin
          bad++;
          $display("FAIL sb_xfer: got pc=%h inst=%h expected pc=%h inst=%h at %0t",
                   out_pc, out_inst, ep, ei, $time);
        end
      end
    end
  end

  initial begin
    int since_redir;
    for (int i = 0; i < 64; i++) rom[i] = i;

    // Reset
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk("rst_rom_en", {31'b0, rom_en}, 32'd0);
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // Free run
    rst = 1'b0; out_ready = 1'b1;
    push_stream(PC_RST);
    #1;
    chk("run_first_valid", {31'b0, out_valid}, 32'd0);
    chk("run_first_addr", {26'b0, rom_addr}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("run_valid", {31'b0, out_valid}, 32'd1);
      chk("run_pc", out_pc, 32'(4 * k));
      chk("run_inst", out_inst, 32'(k));
    end

    // Stall on out_pc=8
    step();
    out_ready = 1'b0;
    #1;
    chk("stall_pc0", out_pc, 32'h8);
    chk("stall_rom_en0", {31'b0, rom_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", out_pc, 32'h8);
      chk("stall_inst", out_inst, 32'd2);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_rom_en", {31'b0, rom_en}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("resume_pc", out_pc, 32'hC);
    chk("resume_inst", out_inst, 32'd3);

    // Redirect while out_pc=0x10 (that word still transfers)
    step();
    chk("pre_redir_pc", out_pc, 32'h10);
    do_redirect(32'h40);
    chk("redir_gap", {31'b0, out_valid}, 32'd0);
    step();
    chk("redir_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_pc", out_pc, 32'h40);
    chk("redir_inst", out_inst, 32'd16);
    step();
    chk("redir_pc1", out_pc, 32'h44);
    step();
    chk("redir_pc2", out_pc, 32'h48);

    // ROM address wrap
    do_redirect(32'hFC);
    step();
    chk("wrap_pc0", out_pc, 32'hFC);
    chk("wrap_inst0", out_inst, 32'd63);
    chk("wrap_addr", {26'b0, rom_addr}, 32'd0);
    step();
    chk("wrap_pc1", out_pc, 32'h100);
    chk("wrap_inst1", out_inst, 32'd0);
    step();
    chk("wrap_pc2", out_pc, 32'h104);

    // PC wrap at 2^32
    do_redirect(32'hFFFF_FFFC);
    step();
    chk("pcwrap_pc0", out_pc, 32'hFFFF_FFFC);
    step();
    chk("pcwrap_pc1", out_pc, 32'h0);
    chk("pcwrap_inst1", out_inst, 32'd0);

    // Reset mid-stall
    out_ready = 1'b0;
    step();
    chk("rst_stall_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall_rom_en", {31'b0, rom_en}, 32'd0);
    step();
    rst = 1'b0;
    push_stream(PC_RST);
    chk("rst_stall_drop", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("rst_restart_pc", out_pc, PC_RST);
    chk("rst_restart_valid", {31'b0, out_valid}, 32'd1);

    // Misaligned redirect
`ifdef IF_MISALIGN_CHK_EN
    do_redirect(32'h22);
    exp_pc_q.delete();
    exp_inst_q.delete();
    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("mis_valid", {31'b0, out_valid}, 32'd0);
      chk("mis_rom_en", {31'b0, rom_en}, 32'd0);
      step();
    end
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    push_stream(PC_RST);
    chk("mis_err_clr", {31'b0, fetch_err}, 32'd0);
    out_ready = 1'b1;
`else
    do_redirect(32'h22);
    step();
    chk("mis_pc0", out_pc, 32'h22);
    chk("mis_inst0", out_inst, 32'd8);
    step();
    chk("mis_pc1", out_pc, 32'h26);
    chk("mis_inst1", out_inst, 32'd9);
    chk("mis_err0", {31'b0, fetch_err}, 32'd0);
`endif

    // Randomized traffic
    since_redir = 0;
    ntx = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        push_stream(PC_RST);
        since_redir = 0;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0 || since_redir > 40) begin
          do_redirect($urandom & 32'hFFFF_FFFC);
          since_redir = 0;
        end else begin
          step();
          since_redir++;
        end
      end
    end
    out_ready = 1'b0;
    step();
    chk("rand_progress", {31'b0, (ntx > 1000)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
